// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the UART boot loader.
// Holds the loader and receiver state encodings and the default frame sync byte.
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling.
// Ports: CLK clock, RST sync active-high reset, RX async serial input (idle high),
//        rx_data received byte, rx_valid one-cycle good-byte strobe,
//        rx_ferr one-cycle framing-error strobe (stop bit was 0).
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          rx_s, fall, tick, half;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;
    assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
    // The start bit is confirmed half a bit after the edge; later samples then land mid-bit.
    assign half = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= R_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RX};
            prev_q  <= rx_s;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            R_IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = fall ? R_START : R_IDLE;
            end
            R_START: if (half) begin
                cnt_d   = '0;
                state_d = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (tick) begin
                cnt_d   = '0;
                data_d  = {rx_s, data_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP: if (tick) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rx_data  = data_q;
        rx_valid = (state_q == R_STOP) && tick && rx_s;
        rx_ferr  = (state_q == R_STOP) && tick && !rx_s;
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program frame over UART and writes it into memory, holding the CPU in reset until verified.
// Ports: CLK clock, RST sync active-high reset, RX UART input,
//        MEM_WE/MEM_ADDR/MEM_WDATA memory write port, CPU_RST CPU reset (1 = held),
//        DONE last frame verified, ERR last frame failed.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        CPU_RST,
    output logic        DONE,
    output logic        ERR
);

    boot_state_e state_q, state_d;
    logic [8:0]  n_q, n_d, idx_q, idx_d;
    logic [7:0]  hi_q, hi_d, csum_q, csum_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr, sync_hit, in_frame;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLK     (CLK),
        .RST     (RST),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
    assign in_frame = (state_q == S_CNT) || (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CSUM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = sync_hit ? S_CNT : state_q;
            S_CNT: if (rx_valid) begin
                // A count byte of zero stands for 256 words.
                n_d     = {rx_data == 8'd0, rx_data};
                idx_d   = '0;
                csum_d  = '0;
                state_d = S_HI;
            end
            S_HI: if (rx_valid) begin
                hi_d    = rx_data;
                csum_d  = csum_q ^ rx_data;
                state_d = S_LO;
            end
            S_LO: if (rx_valid) begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + 16'(idx_q);
                wdata_d = {hi_q, rx_data};
                csum_d  = csum_q ^ rx_data;
                idx_d   = idx_q + 9'd1;
                state_d = (idx_q + 9'd1 == n_q) ? S_CSUM : S_HI;
            end
            S_CSUM: if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (rx_ferr && in_frame) state_d = S_ERR;
    end

    always_comb begin
        MEM_WE    = we_q;
        MEM_ADDR  = addr_q;
        MEM_WDATA = wdata_q;
        CPU_RST   = state_q != S_DONE;
        DONE      = state_q == S_DONE;
        ERR       = state_q == S_ERR;
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed self-checking bench for boot_loader.
module tb_boot_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic        we0, crst0, done0, err0;
    logic        we1, crst1, done1, err1;
    logic [15:0] addr0, wd0, addr1, wd1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nval0 = 0;
    int vcyc0 = 0;
    int done_lat0 = -1;
    logic done_prev0 = 1'b0;
    logic [15:0] wa0[$];
    logic [15:0] wdq0[$];
    int          wl0[$];
    logic [15:0] wa1[$];
    logic [15:0] wdq1[$];

    always #5 clk = ~clk;

    boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000), .SYNC_BYTE(8'hA5)) dut0 (
        .CLK(clk), .RST(rst), .RX(rx0), .MEM_WE(we0), .MEM_ADDR(addr0), .MEM_WDATA(wd0),
        .CPU_RST(crst0), .DONE(done0), .ERR(err0)
    );

    boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFF80), .SYNC_BYTE(8'hA5)) dut1 (
        .CLK(clk), .RST(rst), .RX(rx1), .MEM_WE(we1), .MEM_ADDR(addr1), .MEM_WDATA(wd1),
        .CPU_RST(crst1), .DONE(done1), .ERR(err1)
    );

    always @(negedge clk) begin
        cyc++;
        if (dut0.u_rx.rx_valid) begin
            nval0++;
            vcyc0 = cyc;
        end
        if (we0) begin
            wa0.push_back(addr0);
            wdq0.push_back(wd0);
            wl0.push_back(cyc - vcyc0);
        end
        if (done0 && !done_prev0) done_lat0 = cyc - vcyc0;
        done_prev0 = done0;
        if (we1) begin
            wa1.push_back(addr1);
            wdq1.push_back(wd1);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel) rx1 = f[i]; else rx0 = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (sel) rx1 = 1'b1; else rx0 = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] last);
        logic [7:0] fr [9];
        fr = '{8'hA5, 8'h03, 8'h15, 8'h01, 8'h17, 8'h02, 8'h34, 8'h30, 8'h05};
        fr[8] = last;
        for (int i = 0; i < 9; i++) send_byte(1'b0, fr[i], 1'b1);
    endtask

    task automatic clear0();
        wa0.delete();
        wdq0.delete();
        wl0.delete();
        done_lat0 = -1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (we0 !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", we0); end
        total++; if (addr0 !== 16'h0000) begin bad++; $display("FAIL rst_addr0 got=%h want=0000", addr0); end
        total++; if (wd0 !== 16'h0000) begin bad++; $display("FAIL rst_wdata got=%h want=0000", wd0); end
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst got=%b want=1", crst0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err0); end
        total++; if (addr1 !== 16'hFF80) begin bad++; $display("FAIL rst_addr1 got=%h want=ff80", addr1); end
        total++; if (crst1 !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst1 got=%b want=1", crst1); end
    endtask

    task automatic test_good_frame();
        logic [15:0] ea [3];
        logic [15:0] ed [3];
        ea = '{16'h0000, 16'h0001, 16'h0002};
        ed = '{16'h1501, 16'h1702, 16'h3430};
        clear0();
        send_frame(8'h05);
        total++; if (wa0.size() !== 3) begin bad++; $display("FAIL good_nwrites got=%0d want=3", wa0.size()); end
        if (wa0.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (wa0[i] !== ea[i]) begin bad++; $display("FAIL good_addr%0d got=%h want=%h", i, wa0[i], ea[i]); end
                total++; if (wdq0[i] !== ed[i]) begin bad++; $display("FAIL good_data%0d got=%h want=%h", i, wdq0[i], ed[i]); end
                total++; if (wl0[i] !== 1) begin bad++; $display("FAIL good_lat%0d got=%0d want=1", i, wl0[i]); end
            end
        end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL good_done got=%b want=1", done0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL good_err got=%b want=0", err0); end
        total++; if (crst0 !== 1'b0) begin bad++; $display("FAIL good_cpu_rst got=%b want=0", crst0); end
        total++; if (done_lat0 !== 1) begin bad++; $display("FAIL good_done_lat got=%0d want=1", done_lat0); end
    endtask

    task automatic test_bad_csum();
        clear0();
        send_frame(8'h06);
        total++; if (wa0.size() !== 3) begin bad++; $display("FAIL badcs_nwrites got=%0d want=3", wa0.size()); end
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL badcs_err got=%b want=1", err0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL badcs_done got=%b want=0", done0); end
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL badcs_cpu_rst got=%b want=1", crst0); end
        clear0();
        send_frame(8'h05);
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL rearm_done got=%b want=1", done0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rearm_err got=%b want=0", err0); end
        total++; if (crst0 !== 1'b0) begin bad++; $display("FAIL rearm_cpu_rst got=%b want=0", crst0); end
    endtask

    task automatic test_noise();
        int nv;
        pulse_rst();
        clear0();
        nv = nval0;
        send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b0, 8'hFF, 1'b1);
        total++; if (nval0 - nv !== 2) begin bad++; $display("FAIL noise_bytes got=%0d want=2", nval0 - nv); end
        rx0 = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (nval0 - nv !== 2) begin bad++; $display("FAIL glitch_valid got=%0d want=2", nval0 - nv); end
        total++; if (wa0.size() !== 0) begin bad++; $display("FAIL noise_writes got=%0d want=0", wa0.size()); end
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL noise_cpu_rst got=%b want=1", crst0); end
        send_frame(8'h05);
        total++; if (wa0.size() !== 3) begin bad++; $display("FAIL noise_frame_nwrites got=%0d want=3", wa0.size()); end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL noise_frame_done got=%b want=1", done0); end
    endtask

    task automatic test_ferr();
        pulse_rst();
        clear0();
        send_byte(1'b0, 8'hA5, 1'b1);
        send_byte(1'b0, 8'h02, 1'b1);
        send_byte(1'b0, 8'h11, 1'b1);
        send_byte(1'b0, 8'h22, 1'b0);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL ferr_err got=%b want=1", err0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL ferr_done got=%b want=0", done0); end
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL ferr_cpu_rst got=%b want=1", crst0); end
        total++; if (wa0.size() !== 0) begin bad++; $display("FAIL ferr_writes got=%0d want=0", wa0.size()); end
        send_byte(1'b0, 8'h33, 1'b1);
        send_byte(1'b0, 8'h44, 1'b1);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL ferr_hold_err got=%b want=1", err0); end
        total++; if (wa0.size() !== 0) begin bad++; $display("FAIL ferr_hold_writes got=%0d want=0", wa0.size()); end
    endtask

    task automatic test_rst_mid();
        send_frame(8'h05);
        total++; if (addr0 !== 16'h0002) begin bad++; $display("FAIL mid_pre_addr got=%h want=0002", addr0); end
        clear0();
        send_byte(1'b0, 8'hA5, 1'b1);
        send_byte(1'b0, 8'h02, 1'b1);
        send_byte(1'b0, 8'h12, 1'b1);
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL mid_rearm_cpu_rst got=%b want=1", crst0); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (we0 !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b want=0", we0); end
        total++; if (addr0 !== 16'h0000) begin bad++; $display("FAIL mid_rst_addr got=%h want=0000", addr0); end
        total++; if (wd0 !== 16'h0000) begin bad++; $display("FAIL mid_rst_wdata got=%h want=0000", wd0); end
        total++; if (crst0 !== 1'b1) begin bad++; $display("FAIL mid_rst_cpu_rst got=%b want=1", crst0); end
        total++; if (done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b want=00", done0, err0); end
        rst = 1'b0;
        @(negedge clk);
        clear0();
        send_frame(8'h05);
        total++; if (wa0.size() !== 3) begin bad++; $display("FAIL mid_reload_nwrites got=%0d want=3", wa0.size()); end
        if (wa0.size() == 3) begin
            total++; if (wa0[0] !== 16'h0000 || wdq0[0] !== 16'h1501) begin bad++; $display("FAIL mid_reload_w0 got=%h:%h want=0000:1501", wa0[0], wdq0[0]); end
            total++; if (wa0[2] !== 16'h0002 || wdq0[2] !== 16'h3430) begin bad++; $display("FAIL mid_reload_w2 got=%h:%h want=0002:3430", wa0[2], wdq0[2]); end
        end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL mid_reload_done got=%b want=1", done0); end
    endtask

    task automatic test_count0();
        logic [7:0] cs;
        logic [7:0] hi, lo;
        int nerr;
        wa1.delete();
        wdq1.delete();
        cs = 8'h00;
        send_byte(1'b1, 8'hA5, 1'b1);
        send_byte(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            hi = 8'(i);
            lo = 8'(i * i + 7);
            cs = cs ^ hi ^ lo;
            send_byte(1'b1, hi, 1'b1);
            send_byte(1'b1, lo, 1'b1);
        end
        send_byte(1'b1, cs, 1'b1);
        total++; if (wa1.size() !== 256) begin bad++; $display("FAIL c0_nwrites got=%0d want=256", wa1.size()); end
        if (wa1.size() == 256) begin
            total++; if (wa1[127] !== 16'hFFFF) begin bad++; $display("FAIL c0_addr127 got=%h want=ffff", wa1[127]); end
            total++; if (wa1[128] !== 16'h0000) begin bad++; $display("FAIL c0_addr128 got=%h want=0000", wa1[128]); end
            total++; if (wa1[255] !== 16'h007F) begin bad++; $display("FAIL c0_addr255 got=%h want=007f", wa1[255]); end
            nerr = 0;
            for (int i = 0; i < 256; i++) begin
                if (wa1[i] !== 16'hFF80 + 16'(i) || wdq1[i] !== {8'(i), 8'(i * i + 7)}) nerr++;
            end
            total++; if (nerr !== 0) begin bad++; $display("FAIL c0_words got=%0d bad words want=0", nerr); end
        end
        total++; if (done1 !== 1'b1) begin bad++; $display("FAIL c0_done got=%b want=1", done1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL c0_err got=%b want=0", err1); end
        total++; if (crst1 !== 1'b0) begin bad++; $display("FAIL c0_cpu_rst got=%b want=0", crst1); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_noise();
        test_ferr();
        test_rst_mid();
        test_count0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
